mem_stack_unit: RTL and testbench

Parametrised successor to the memory-stage data/stack logic. It is a single-ported data memory with an integrated stack pointer and a multi-word transfer sequencer. LOAD/STORE move one word at an explicit address. PUSH/POP move 1..MAX_WORDS words through SP, stalling upstream until the sequence completes. It sits in the MEM stage between the EX_MEM and MEM_WB buffers, and generalises the fixed two-word PC push/pop to any width, depth and entry size.

---
 rtl/mem_stack_unit_if.sv | 33 +++
 rtl/mem_stack_unit.sv | 187 ++++++++++++++++++
 tb/tb_mem_stack_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stack_unit_if.sv
// mem_stack_unit_if
// Request/response bundle between the MEM-stage sequencer and its requester.
//   master : drives req_valid/req_op/req_words/req_addr/req_wdata,
//            observes req_ready and the resp_* return path.
//   slave  : the mem_stack_unit side of the same signals.
// Word k of req_wdata / resp_rdata occupies bits [k*DATA_W +: DATA_W].
interface mem_stack_unit_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 2
);
  localparam int CNT_W = $clog2(MAX_WORDS) + 1;

  logic                          req_valid;
  logic [1:0]                    req_op;
  logic [CNT_W-1:0]              req_words;
  logic [ADDR_W-1:0]             req_addr;
  logic [DATA_W*MAX_WORDS-1:0]   req_wdata;
  logic                          req_ready;
  logic                          resp_valid;
  logic [DATA_W*MAX_WORDS-1:0]   resp_rdata;
  logic                          resp_err;

  modport master (
    output req_valid, req_op, req_words, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_words, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_stack_unit.sv
// mem_stack_unit
// Single-ported data memory with an integrated stack pointer and a
// multi-word PUSH/POP sequencer (MEM stage).
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-low reset
//   bus       : mem_stack_unit_if.slave (req_*/resp_* handshake)
//   stall_out : ~req_ready, freezes earlier pipeline stages
//   sp_out    : registered stack pointer
// Optional build macro STACK_GUARD_EN: bounds-check PUSH/POP at acceptance
// and answer an out-of-range request with resp_err=1 and no memory access.
module mem_stack_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int MAX_WORDS   = 2,
  parameter int SP_RESET    = (2**ADDR_W) - 1,
  parameter int STACK_LIMIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  mem_stack_unit_if.slave   bus,
  output logic              stall_out,
  output logic [ADDR_W-1:0] sp_out
);
  localparam int CNT_W = $clog2(MAX_WORDS) + 1;
  localparam int BUF_W = DATA_W * MAX_WORDS;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  logic [0:0]        state_reg;
  logic [1:0]        op_reg;
  logic [CNT_W-1:0]  n_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [BUF_W-1:0]  wdata_reg;
  logic [BUF_W-1:0]  rbuf_reg;
  logic [BUF_W-1:0]  rbuf_next;
  logic [ADDR_W-1:0] sp_reg;
  logic              resp_valid_reg;
  logic [BUF_W-1:0]  resp_rdata_reg;
  logic              rej_pend_reg;   // rejected request waiting to report

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              accept;
  logic              reject_req;
  logic [CNT_W-1:0]  req_n;
  logic [CNT_W-1:0]  push_idx;
  logic [DATA_W-1:0] push_word;
  logic              last_beat;
  logic              do_read;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign bus.req_ready  = (state_reg == ST_IDLE) && !rej_pend_reg;
  assign stall_out      = ~bus.req_ready;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign sp_out         = sp_reg;

  // Word count: single-word ops ignore req_words; stack ops clamp to 1..MAX_WORDS.
  always_comb begin
    req_n = bus.req_words;
    if (bus.req_op == OP_LOAD || bus.req_op == OP_STORE) begin
      req_n = CNT_W'(1);
    end else if (bus.req_words == '0) begin
      req_n = CNT_W'(1);
    end else if (bus.req_words > CNT_W'(MAX_WORDS)) begin
      req_n = CNT_W'(MAX_WORDS);
    end
  end

`ifdef STACK_GUARD_EN
  logic resp_err_reg;
  int   push_room;
  int   pop_room;

  always_comb begin
    push_room  = int'(sp_reg) - STACK_LIMIT + 1;
    pop_room   = SP_RESET - int'(sp_reg);
    reject_req = ((bus.req_op == OP_PUSH) && (int'(req_n) > push_room)) ||
                 ((bus.req_op == OP_POP)  && (int'(req_n) > pop_room));
  end

  assign bus.resp_err = resp_err_reg;
`else
  assign reject_req   = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // PUSH stores the highest word first so POP can return the lowest first.
  assign push_idx = n_reg - CNT_W'(1) - cnt_reg;

  always_comb begin
    push_word = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (push_idx == CNT_W'(k)) push_word = wdata_reg[k*DATA_W +: DATA_W];
    end
  end

  assign last_beat = (cnt_reg == n_reg - CNT_W'(1));
  assign do_read   = (state_reg == ST_XFER) && (op_reg == OP_LOAD || op_reg == OP_POP);
  assign mem_we    = (state_reg == ST_XFER) && (op_reg == OP_STORE || op_reg == OP_PUSH);
  assign mem_waddr = (op_reg == OP_PUSH) ? sp_reg : addr_reg;
  assign mem_wdata = (op_reg == OP_PUSH) ? push_word : wdata_reg[DATA_W-1:0];
  // SP points at the next free slot, so POP reads one above it.
  assign rd_addr   = (op_reg == OP_POP) ? sp_reg + ADDR_W'(1) : addr_reg;
  assign rd_data   = mem[rd_addr];

  // The beat's read lands in word cnt (always word 0 for LOAD).
  for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_rbuf
    assign rbuf_next[gi*DATA_W +: DATA_W] =
      (do_read && cnt_reg == CNT_W'(gi)) ? rd_data : rbuf_reg[gi*DATA_W +: DATA_W];
  end

  // Memory is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_LOAD;
      n_reg          <= CNT_W'(1);
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rbuf_reg       <= '0;
      sp_reg         <= ADDR_W'(SP_RESET);
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      rej_pend_reg   <= 1'b0;
`ifdef STACK_GUARD_EN
      resp_err_reg   <= 1'b0;
`endif
    end else begin
      resp_valid_reg <= 1'b0;
`ifdef STACK_GUARD_EN
      resp_err_reg   <= 1'b0;
      if (rej_pend_reg) begin
        rej_pend_reg   <= 1'b0;
        resp_valid_reg <= 1'b1;
        resp_err_reg   <= 1'b1;
      end
`endif
      case (state_reg)
        ST_IDLE: begin
          if (accept && reject_req) begin
            rej_pend_reg <= 1'b1;
          end else if (accept) begin
            state_reg <= ST_XFER;
            op_reg    <= bus.req_op;
            n_reg     <= req_n;
            cnt_reg   <= '0;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            rbuf_reg  <= '0;
          end
        end
        ST_XFER: begin
          rbuf_reg <= rbuf_next;
          if (op_reg == OP_PUSH)     sp_reg <= sp_reg - ADDR_W'(1);
          else if (op_reg == OP_POP) sp_reg <= sp_reg + ADDR_W'(1);
          if (last_beat) begin
            state_reg      <= ST_IDLE;
            resp_valid_reg <= 1'b1;
            if (do_read) resp_rdata_reg <= rbuf_next;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stack_unit.sv
module tb_mem_stack_unit;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall_out;
  logic [11:0] sp_out;
  int          total;
  int          bad;
  exp_t        sb_q[$];

  mem_stack_unit_if #(.DATA_W(16), .ADDR_W(12), .MAX_WORDS(2)) bus ();

  mem_stack_unit #(
    .DATA_W(16), .ADDR_W(12), .MAX_WORDS(2), .SP_RESET(4095), .STACK_LIMIT(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .stall_out(stall_out),
    .sp_out(sp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sp(input string name, input logic [11:0] want);
    total++;
    if (sp_out !== want) begin
      bad++;
      $display("FAIL %s sp_out got=%0d want=%0d", name, sp_out, want);
    end
  endtask

  // Present a request, let it be accepted, and log the expected response.
  task automatic send_req(input logic [1:0] op, input logic [1:0] words,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [31:0] e_rdata, input logic e_err,
                          input logic e_chk);
    exp_t e;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_accept got=%b want=1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_words = words;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    bus.req_addr  = 12'($urandom);
    e.rdata = e_rdata;
    e.err = e_err;
    e.chk_rdata = e_chk;
    sb_q.push_back(e);
    total++;
    if (bus.req_ready !== 1'b0 || stall_out !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept ready=%b stall=%b want ready=0 stall=1",
               bus.req_ready, stall_out);
    end
  endtask

  // Wait (bounded) for resp_valid, then pop and compare the scoreboard entry.
  task automatic wait_resp(input string name, input int exp_edges);
    int   c;
    exp_t e;
    c = 0;
    while (bus.resp_valid !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    total++;
    if (bus.resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s resp_valid timeout got=%b want=1", name, bus.resp_valid);
      return;
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected response got=resp want=none", name);
      return;
    end
    e = sb_q.pop_front();
    total++;
    if (c != exp_edges) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d edges", name, c, exp_edges);
    end
    if (e.chk_rdata) begin
      total++;
      if (bus.resp_rdata !== e.rdata) begin
        bad++;
        $display("FAIL %s resp_rdata got=%h want=%h", name, bus.resp_rdata, e.rdata);
      end
    end
    total++;
    if (bus.resp_err !== e.err) begin
      bad++;
      $display("FAIL %s resp_err got=%b want=%b", name, bus.resp_err, e.err);
    end
    $display("txn %s rdata=%h err=%b edges=%0d sp=%0d", name, bus.resp_rdata,
             bus.resp_err, c, sp_out);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LOAD;
    bus.req_words = 2'd0;
    bus.req_addr  = 12'd0;
    bus.req_wdata = 32'd0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_sp("reset", 12'd4095);
    total++;
    if (bus.req_ready !== 1'b1 || stall_out !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs ready=%b stall=%b valid=%b rdata=%h want 1 0 0 00000000",
               bus.req_ready, stall_out, bus.resp_valid, bus.resp_rdata);
    end
  endtask

  task automatic test_push();
    send_req(OP_PUSH, 2'd2, 12'd0, 32'hABCD_1234, 32'd0, 1'b0, 1'b1);
    check_sp("push_accept", 12'd4095);
    tick();
    check_sp("push_beat0", 12'd4094);
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL push_beat0 ready=%b valid=%b want ready=0 valid=0",
               bus.req_ready, bus.resp_valid);
    end
    wait_resp("push2", 1);
    check_sp("push_done", 12'd4093);
    tick();
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL push_pulse resp_valid got=%b want=0", bus.resp_valid);
    end
  endtask

  task automatic test_pop();
    send_req(OP_POP, 2'd2, 12'd0, 32'h0, 32'hABCD_1234, 1'b0, 1'b1);
    wait_resp("pop2", 2);
    check_sp("pop_done", 12'd4095);
  endtask

  task automatic test_back_to_back();
    send_req(OP_STORE, 2'd2, 12'h010, 32'h9999_5A5A, 32'hABCD_1234, 1'b0, 1'b1);
    wait_resp("store", 1);
    send_req(OP_LOAD, 2'd2, 12'h010, 32'hFFFF_FFFF, 32'h0000_5A5A, 1'b0, 1'b1);
    check_sp("load_busy", 12'd4095);
    wait_resp("load", 1);
    check_sp("load_done", 12'd4095);
  endtask

  task automatic test_clamp();
    send_req(OP_PUSH, 2'd0, 12'd0, 32'hAAAA_5555, 32'h0000_5A5A, 1'b0, 1'b1);
    wait_resp("push_w0", 1);
    check_sp("push_w0", 12'd4094);
    send_req(OP_POP, 2'd0, 12'd0, 32'h0, 32'h0000_5555, 1'b0, 1'b1);
    wait_resp("pop_w0", 1);
    check_sp("pop_w0", 12'd4095);
    send_req(OP_PUSH, 2'd3, 12'd0, 32'h1111_2222, 32'h0000_5555, 1'b0, 1'b1);
    wait_resp("push_w3", 2);
    check_sp("push_w3", 12'd4093);
    send_req(OP_POP, 2'd2, 12'd0, 32'h0, 32'h1111_2222, 1'b0, 1'b1);
    wait_resp("pop_w2", 2);
    check_sp("pop_w2", 12'd4095);
  endtask

  task automatic test_reset_mid();
    bit seen;
    send_req(OP_PUSH, 2'd2, 12'd0, 32'h7777_BEEF, 32'h1111_2222, 1'b0, 1'b1);
    tick();
    check_sp("mid_beat0", 12'd4094);
    #1;
    reset = 1'b0;
    #1;
    check_sp("mid_in_reset", 12'd4095);
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs ready=%b valid=%b rdata=%h want 1 0 00000000",
               bus.req_ready, bus.resp_valid, bus.resp_rdata);
    end
    sb_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.resp_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_no_resp resp_valid got=1 want=0");
    end
    check_sp("mid_after", 12'd4095);
    send_req(OP_LOAD, 2'd1, 12'hFFF, 32'h0, 32'h0000_7777, 1'b0, 1'b1);
    wait_resp("load_fff", 1);
  endtask

  task automatic test_pop_empty();
`ifdef STACK_GUARD_EN
    send_req(OP_POP, 2'd1, 12'd0, 32'h0, 32'h0000_7777, 1'b1, 1'b1);
    wait_resp("pop_empty_guard", 1);
    check_sp("pop_empty_guard", 12'd4095);
`else
    send_req(OP_POP, 2'd1, 12'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    wait_resp("pop_empty_wrap", 1);
    check_sp("pop_empty_wrap", 12'd0);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_push();
    test_pop();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_pop_empty();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
